// File: rtl/flash_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_writer_pkg
//  Description : Shared definitions for the flash write path. Holds the Intel
//                CFI command bytes, the status register bit indices, the
//                address/data types, the FSM state encodings and small
//                helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package flash_writer_pkg;

    typedef logic [22:0] Flash_addr_t;
    typedef logic [15:0] Halfword_t;

    // CFI command bytes, placed on the low byte of the data bus.
    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
    localparam logic [7:0] CMD_READ_SR    = 8'h70;
    localparam logic [7:0] CMD_CLEAR_SR   = 8'h50;
    localparam logic [7:0] CMD_PROGRAM    = 8'h40;
    localparam logic [7:0] CMD_ERASE      = 8'h20;
    localparam logic [7:0] CMD_CONFIRM    = 8'hD0;

    // Status register bit indices.
    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPEN_ERR  = 3;
    localparam int SR_LOCK_ERR  = 1;

    // Command sequencer states.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLR      = 4'd1,
        S_SETUP    = 4'd2,
        S_DATA     = 4'd3,
        S_POLL_CMD = 4'd4,
        S_POLL_RD  = 4'd5,
        S_ERR_CLR  = 4'd6,
        S_RD_ARRAY = 4'd7,
        S_VERIFY   = 4'd8,
        S_DONE     = 4'd9
    } wr_state_e;

    // Single bus-cycle engine states.
    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_SETUP = 3'd1,
        C_WE    = 3'd2,
        C_REC   = 3'd3,
        C_OE    = 3'd4,
        C_GAP   = 3'd5
    } cyc_state_e;

    // Any fault bit in a ready status word.
    function automatic logic sr_fault(input logic [7:0] sr);
        return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPEN_ERR] | sr[SR_LOCK_ERR];
    endfunction

    // Command byte widened to the 16-bit data bus.
    function automatic Halfword_t cmd_word(input logic [7:0] cmd);
        return {8'h00, cmd};
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : flash_bus_cycle
//  Description : Executes one timed flash bus cycle.
//                Write: address/data set up one cycle, we_n low
//                WE_PULSE_CYCLES, we_n high RECOVERY_CYCLES. flash_d is
//                released on the same edge that raises we_n.
//                Read : oe_n low OE_CYCLES, data sampled on the last low
//                cycle, oe_n high one cycle.
//                ack pulses for one cycle when the cycle is complete; a new
//                start is accepted in the ack cycle.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                start, is_write   launch a cycle (write when is_write=1)
//                addr, wdata       cycle address and write data
//                ack, rdata        completion pulse, sampled read data
//                flash_a, flash_d  flash address bus, tri-state data bus
//                flash_we_n/oe_n   flash strobes, active low
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_bus_cycle
    import flash_writer_pkg::*;
#(
    parameter int WE_PULSE_CYCLES = 3,
    parameter int RECOVERY_CYCLES = 2,
    parameter int OE_CYCLES       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_write,
    input  Flash_addr_t addr,
    input  Halfword_t   wdata,
    output logic        ack,
    output Halfword_t   rdata,
    output Flash_addr_t flash_a,
    inout  wire [15:0]  flash_d,
    output logic        flash_we_n,
    output logic        flash_oe_n
);

    localparam int CW = 8;

    cyc_state_e  r_state;
    logic [CW-1:0] r_cnt;
    logic        r_drive;
    Halfword_t   r_wdata;
    Flash_addr_t r_addr;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_ack;
    Halfword_t   r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
            r_drive <= 1'b0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (start) begin
                        r_addr <= addr;
                        r_cnt  <= '0;
                        if (is_write) begin
                            r_wdata <= wdata;
                            r_drive <= 1'b1;
                            r_state <= C_SETUP;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_state <= C_OE;
                        end
                    end
                end
                C_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_state <= C_WE;
                end
                C_WE: begin
                    if (r_cnt == CW'(WE_PULSE_CYCLES - 1)) begin
                        // Data hold is covered by the flash latching on the we_n rising edge.
                        r_we_n  <= 1'b1;
                        r_drive <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= C_REC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_REC: begin
                    if (r_cnt == CW'(RECOVERY_CYCLES - 1)) begin
                        r_ack   <= 1'b1;
                        r_state <= C_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_OE: begin
                    if (r_cnt == CW'(OE_CYCLES - 1)) begin
                        r_rdata <= flash_d;
                        r_oe_n  <= 1'b1;
                        r_state <= C_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_GAP: begin
                    r_ack   <= 1'b1;
                    r_state <= C_IDLE;
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign flash_d    = r_drive ? r_wdata : 16'hzzzz;
    assign flash_a    = r_addr;
    assign flash_we_n = r_we_n;
    assign flash_oe_n = r_oe_n;
    assign ack        = r_ack;
    assign rdata      = r_rdata;

endmodule
`default_nettype wire

// File: rtl/flash_writer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_writer
//  Description : Programs one halfword or erases one block in a 16-bit
//                parallel NOR flash (Intel CFI command set). Sequences the
//                command cycles, polls the status register, then restores
//                read-array mode. Pin timing is delegated to flash_bus_cycle.
//                Build option FLASH_WRITER_VERIFY_EN adds a read-back of the
//                programmed halfword; a mismatch raises error.
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                bus_addr, bus_data_write  request address / program data
//                program_op, erase_op      1-cycle requests (erase wins)
//                busy, done, error, status operation status
//                flash_*                   flash device pins
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_writer
    import flash_writer_pkg::*;
#(
    parameter int WE_PULSE_CYCLES = 3,
    parameter int RECOVERY_CYCLES = 2,
    parameter int OE_CYCLES       = 3,
    parameter int TIMEOUT_CYCLES  = 2**24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [15:0] bus_data_write,
    input  logic        program_op,
    input  logic        erase_op,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic [22:0] flash_a,
    inout  wire  [15:0] flash_d,
    output logic        flash_rp_n,
    output logic        flash_vpen,
    output logic        flash_byte_n,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n
);

    wr_state_e   r_state;
    logic        r_is_erase;
    Flash_addr_t r_addr;
    Halfword_t   r_data;
    logic [23:0] r_poll_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [7:0]  r_status;
    logic        r_start;
    logic        r_is_write;
    Halfword_t   r_cyc_wdata;

    logic        w_ack;
    Halfword_t   w_rdata;

    // Upper byte-address bits are outside the 8 MB device window.
    logic        w_unused_addr;
    assign w_unused_addr = ^bus_addr[31:23];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_erase  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_poll_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_status    <= 8'h00;
            r_start     <= 1'b0;
            r_is_write  <= 1'b0;
            r_cyc_wdata <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (erase_op || program_op) begin
                        r_is_erase  <= erase_op;
                        r_addr      <= bus_addr[22:0];
                        r_data      <= bus_data_write;
                        r_busy      <= 1'b1;
                        r_error     <= 1'b0;
                        r_status    <= 8'h00;
                        r_poll_cnt  <= '0;
                        r_start     <= 1'b1;
                        r_is_write  <= 1'b1;
                        r_cyc_wdata <= cmd_word(CMD_CLEAR_SR);
                        r_state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (w_ack) begin
                        r_start     <= 1'b1;
                        r_is_write  <= 1'b1;
                        r_cyc_wdata <= cmd_word(r_is_erase ? CMD_ERASE : CMD_PROGRAM);
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_ack) begin
                        r_start     <= 1'b1;
                        r_is_write  <= 1'b1;
                        r_cyc_wdata <= r_is_erase ? cmd_word(CMD_CONFIRM) : r_data;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_ack) begin
                        r_start     <= 1'b1;
                        r_is_write  <= 1'b1;
                        r_cyc_wdata <= cmd_word(CMD_READ_SR);
                        r_state     <= S_POLL_CMD;
                    end
                end
                S_POLL_CMD: begin
                    if (w_ack) begin
                        r_start    <= 1'b1;
                        r_is_write <= 1'b0;
                        r_state    <= S_POLL_RD;
                    end
                end
                S_POLL_RD: begin
                    if (w_ack) begin
                        // The device stays in SR mode, so re-polling needs no new 0x70.
                        r_status <= w_rdata[7:0];
                        if (w_rdata[SR_READY]) begin
                            r_start    <= 1'b1;
                            r_is_write <= 1'b1;
                            if (sr_fault(w_rdata[7:0])) begin
                                r_error     <= 1'b1;
                                r_cyc_wdata <= cmd_word(CMD_CLEAR_SR);
                                r_state     <= S_ERR_CLR;
                            end else begin
                                r_cyc_wdata <= cmd_word(CMD_READ_ARRAY);
                                r_state     <= S_RD_ARRAY;
                            end
                        end else if (r_poll_cnt == 24'(TIMEOUT_CYCLES - 1)) begin
                            // Last allowed poll still busy; SR[7]=0 lands in status.
                            r_error     <= 1'b1;
                            r_start     <= 1'b1;
                            r_is_write  <= 1'b1;
                            r_cyc_wdata <= cmd_word(CMD_CLEAR_SR);
                            r_state     <= S_ERR_CLR;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 24'd1;
                            r_start    <= 1'b1;
                            r_is_write <= 1'b0;
                        end
                    end
                end
                S_ERR_CLR: begin
                    if (w_ack) begin
                        r_start     <= 1'b1;
                        r_is_write  <= 1'b1;
                        r_cyc_wdata <= cmd_word(CMD_READ_ARRAY);
                        r_state     <= S_RD_ARRAY;
                    end
                end
                S_RD_ARRAY: begin
                    if (w_ack) begin
`ifdef FLASH_WRITER_VERIFY_EN
                        if (!r_is_erase) begin
                            r_start    <= 1'b1;
                            r_is_write <= 1'b0;
                            r_state    <= S_VERIFY;
                        end else begin
                            r_state <= S_DONE;
                        end
`else
                        r_state <= S_DONE;
`endif
                    end
                end
                S_VERIFY: begin
                    if (w_ack) begin
                        if (w_rdata != r_data) begin
                            r_error <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // done and the falling busy become visible together.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef FLASH_WRITER_VERIFY_EN
    // Only the status byte of a read is consumed without read-back.
    logic w_unused_rdata;
    assign w_unused_rdata = ^w_rdata[15:8];
`endif

    flash_bus_cycle #(
        .WE_PULSE_CYCLES (WE_PULSE_CYCLES),
        .RECOVERY_CYCLES (RECOVERY_CYCLES),
        .OE_CYCLES       (OE_CYCLES)
    ) u_bus_cycle (
        .clk        (clk),
        .rst        (rst),
        .start      (r_start),
        .is_write   (r_is_write),
        .addr       (r_addr),
        .wdata      (r_cyc_wdata),
        .ack        (w_ack),
        .rdata      (w_rdata),
        .flash_a    (flash_a),
        .flash_d    (flash_d),
        .flash_we_n (flash_we_n),
        .flash_oe_n (flash_oe_n)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign status       = r_status;
    assign flash_rp_n   = 1'b1;
    assign flash_vpen   = 1'b1;
    assign flash_byte_n = 1'b1;
    assign flash_ce_n   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_flash_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_writer
//  Description : Directed self-checking bench for flash_writer with a small
//                behavioural CFI flash model (SR readiness after a set
//                number of polls, programmable SR value, optional corruption
//                of programmed data).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr;
    logic [15:0] bus_data_write;
    logic        program_op;
    logic        erase_op;
    logic        busy, done, error;
    logic [7:0]  status;
    logic [22:0] flash_a;
    wire  [15:0] flash_d;
    logic        flash_rp_n, flash_vpen, flash_byte_n, flash_ce_n, flash_oe_n, flash_we_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flash_writer #(
        .WE_PULSE_CYCLES (3),
        .RECOVERY_CYCLES (2),
        .OE_CYCLES       (3),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_addr       (bus_addr),
        .bus_data_write (bus_data_write),
        .program_op     (program_op),
        .erase_op       (erase_op),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .status         (status),
        .flash_a        (flash_a),
        .flash_d        (flash_d),
        .flash_rp_n     (flash_rp_n),
        .flash_vpen     (flash_vpen),
        .flash_byte_n   (flash_byte_n),
        .flash_ce_n     (flash_ce_n),
        .flash_oe_n     (flash_oe_n),
        .flash_we_n     (flash_we_n)
    );

    // ---------------- flash model ----------------
    int          m_busy_polls = 0;     // polls answered not-ready before SR[7]=1
    logic [7:0]  m_sr         = 8'h80; // SR returned once ready
    bit          m_corrupt    = 1'b0;  // store data ^ 0x0004
    bit          m_mode_sr    = 1'b0;
    bit          m_expect_data = 1'b0;
    bit          m_expect_conf = 1'b0;
    int          m_polls      = 0;
    logic [22:0] m_last_a     = '0;
    logic [15:0] m_last_d     = 16'hFFFF;
    logic [15:0] log_d [0:63];
    logic [22:0] log_a [0:63];
    int          log_n        = 0;
    logic [15:0] m_rd;

    assign m_rd = m_mode_sr ? {8'h00, (m_polls >= m_busy_polls) ? m_sr : 8'h00}
                            : ((flash_a == m_last_a) ? m_last_d : 16'hFFFF);
    assign flash_d = (flash_oe_n == 1'b0) ? m_rd : 16'hzzzz;

    always @(negedge flash_we_n or posedge flash_oe_n) begin
        if (flash_we_n == 1'b0) begin
            if (log_n < 64) begin
                log_d[log_n] = flash_d;
                log_a[log_n] = flash_a;
            end
            log_n = log_n + 1;
            if (m_expect_data) begin
                m_last_a      = flash_a;
                m_last_d      = m_corrupt ? (flash_d ^ 16'h0004) : flash_d;
                m_expect_data = 1'b0;
                m_mode_sr     = 1'b1;
                m_polls       = 0;
            end else begin
                case (flash_d[7:0])
                    8'h70: m_mode_sr = 1'b1;
                    8'hFF: m_mode_sr = 1'b0;
                    8'h40: m_expect_data = 1'b1;
                    8'h20: m_expect_conf = 1'b1;
                    8'hD0: if (m_expect_conf) begin
                        m_expect_conf = 1'b0;
                        m_mode_sr     = 1'b1;
                        m_polls       = 0;
                    end
                    default: ;
                endcase
            end
        end else if (m_mode_sr) begin
            m_polls = m_polls + 1;
        end
    end

    int we_low = 0;
    int oe_low = 0;
    always @(posedge clk) begin
        if (flash_we_n == 1'b0) we_low <= we_low + 1;
        if (flash_oe_n == 1'b0) oe_low <= oe_low + 1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_seq [0:7];

    task automatic check_log(input string tag, input int base, input int cnt);
        check_eq({tag, "_nwrites"}, 32'(log_n - base), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (base + i < 64)
                check_eq($sformatf("%s_w%0d", tag, i), {16'h0, log_d[base + i]}, {16'h0, exp_seq[i]});
        end
    endtask

    task automatic start_req(input bit p, input bit e, input logic [31:0] a, input logic [15:0] d);
        @(negedge clk);
        program_op     = p;
        erase_op       = e;
        bus_addr       = a;
        bus_data_write = d;
        @(negedge clk);
        program_op = 1'b0;
        erase_op   = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic err, output logic [7:0] st);
        bit ok;
        ok  = 1'b0;
        err = 1'b0;
        st  = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok  = 1'b1;
                err = error;
                st  = status;
                check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                break;
            end
        end
        check_eq({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
    endtask

    int          base, we0, oe0, poll_base;
    logic        r_err;
    logic [7:0]  r_st;
    bit          found;

    initial begin
        rst = 1'b1; program_op = 1'b0; erase_op = 1'b0;
        bus_addr = '0; bus_data_write = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset state
        check_eq("rst_busy",   {31'd0, busy},       32'd0);
        check_eq("rst_done",   {31'd0, done},       32'd0);
        check_eq("rst_error",  {31'd0, error},      32'd0);
        check_eq("rst_status", {24'd0, status},     32'h00);
        check_eq("rst_we_n",   {31'd0, flash_we_n}, 32'd1);
        check_eq("rst_oe_n",   {31'd0, flash_oe_n}, 32'd1);
        check_eq("rst_addr",   {9'd0, flash_a},     32'd0);
        check_eq("rst_ties",   {28'd0, flash_rp_n, flash_vpen, flash_byte_n, flash_ce_n}, 32'hE);

        // T1: program 0x1234 at 0x100, ready on 5th poll
        m_busy_polls = 4; m_sr = 8'h80; m_corrupt = 1'b0;
        base = log_n; we0 = we_low; oe0 = oe_low;
        start_req(1'b1, 1'b0, 32'h0000_0100, 16'h1234);
        check_eq("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_done("t1", r_err, r_st);
        check_eq("t1_error",  {31'd0, r_err}, 32'd0);
        check_eq("t1_status", {24'd0, r_st},  32'h80);
        exp_seq[0] = 16'h0050; exp_seq[1] = 16'h0040; exp_seq[2] = 16'h1234;
        exp_seq[3] = 16'h0070; exp_seq[4] = 16'h00FF;
        check_log("t1", base, 5);
        check_eq("t1_data_addr", {9'd0, log_a[base + 2]}, 32'h100);
        check_eq("t1_polls", 32'(m_polls), 32'd5);
        check_eq("t1_we_low_cycles", 32'(we_low - we0), 32'd15);
`ifdef FLASH_WRITER_VERIFY_EN
        check_eq("t1_oe_low_cycles", 32'(oe_low - oe0), 32'd18);
`else
        check_eq("t1_oe_low_cycles", 32'(oe_low - oe0), 32'd15);
`endif
        @(negedge clk);
        check_eq("t1_done_pulse", {31'd0, done}, 32'd0);
        check_eq("t1_status_hold", {24'd0, status}, 32'h80);

        // T2: erase at 0x020000, SR=0xA0 -> extra 0x50 before 0xFF
        m_busy_polls = 2; m_sr = 8'hA0;
        base = log_n;
        start_req(1'b0, 1'b1, 32'h0002_0000, 16'h0000);
        wait_done("t2", r_err, r_st);
        check_eq("t2_error",  {31'd0, r_err}, 32'd1);
        check_eq("t2_status", {24'd0, r_st},  32'hA0);
        exp_seq[0] = 16'h0050; exp_seq[1] = 16'h0020; exp_seq[2] = 16'h00D0;
        exp_seq[3] = 16'h0070; exp_seq[4] = 16'h0050; exp_seq[5] = 16'h00FF;
        check_log("t2", base, 6);
        check_eq("t2_confirm_addr", {9'd0, log_a[base + 2]}, 32'h20000);
        check_eq("t2_polls", 32'(m_polls), 32'd3);

        // T3: never ready -> exactly 16 polls, timeout
        m_busy_polls = 1000; m_sr = 8'h80;
        base = log_n;
        start_req(1'b1, 1'b0, 32'h0000_0400, 16'hFFFF);
        wait_done("t3", r_err, r_st);
        check_eq("t3_error",  {31'd0, r_err}, 32'd1);
        check_eq("t3_status", {24'd0, r_st},  32'h00);
        exp_seq[0] = 16'h0050; exp_seq[1] = 16'h0040; exp_seq[2] = 16'hFFFF;
        exp_seq[3] = 16'h0070; exp_seq[4] = 16'h0050; exp_seq[5] = 16'h00FF;
        check_log("t3", base, 6);
        check_eq("t3_polls", 32'(m_polls), 32'd16);

        // T4: program+erase together -> erase only; program while busy ignored
        m_busy_polls = 0; m_sr = 8'h80;
        base = log_n;
        start_req(1'b1, 1'b1, 32'h0004_0000, 16'h1111);
        repeat (3) @(negedge clk);
        program_op = 1'b1; bus_addr = 32'h0000_0300; bus_data_write = 16'hBEEF;
        @(negedge clk);
        program_op = 1'b0;
        wait_done("t4", r_err, r_st);
        check_eq("t4_error",  {31'd0, r_err}, 32'd0);
        check_eq("t4_status", {24'd0, r_st},  32'h80);
        exp_seq[0] = 16'h0050; exp_seq[1] = 16'h0020; exp_seq[2] = 16'h00D0;
        exp_seq[3] = 16'h0070; exp_seq[4] = 16'h00FF;
        check_log("t4", base, 5);
        check_eq("t4_block_addr", {9'd0, log_a[base + 2]}, 32'h40000);
        repeat (60) @(negedge clk);
        check_eq("t4_no_second_op", 32'(log_n - base), 32'd5);
        check_eq("t4_idle_busy", {31'd0, busy}, 32'd0);

        // T5: reset during POLL_RD, then a clean program
        m_busy_polls = 1000;
        start_req(1'b1, 1'b0, 32'h0000_0500, 16'h5555);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (flash_oe_n == 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t5_poll_reached", {31'd0, found}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_we_n", {31'd0, flash_we_n}, 32'd1);
        check_eq("t5_oe_n", {31'd0, flash_oe_n}, 32'd1);
        check_eq("t5_busy", {31'd0, busy},       32'd0);
        check_eq("t5_addr", {9'd0, flash_a},     32'd0);
        rst = 1'b0;
        m_busy_polls = 2;
        base = log_n;
        start_req(1'b1, 1'b0, 32'h0000_0600, 16'hA5A5);
        wait_done("t5b", r_err, r_st);
        check_eq("t5b_error",  {31'd0, r_err}, 32'd0);
        check_eq("t5b_status", {24'd0, r_st},  32'h80);
        exp_seq[0] = 16'h0050; exp_seq[1] = 16'h0040; exp_seq[2] = 16'hA5A5;
        exp_seq[3] = 16'h0070; exp_seq[4] = 16'h00FF;
        check_log("t5b", base, 5);

`ifdef FLASH_WRITER_VERIFY_EN
        // T6: corrupted program -> verify mismatch
        m_busy_polls = 1; m_corrupt = 1'b1;
        start_req(1'b1, 1'b0, 32'h0000_0700, 16'h1234);
        wait_done("t6", r_err, r_st);
        check_eq("t6_error",  {31'd0, r_err}, 32'd1);
        check_eq("t6_status", {24'd0, r_st},  32'h80);
        m_corrupt = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
